// File: rtl/memory_arbiter.sv
// Arbitrates one single-port memory between instruction fetch (if_*) and data access (dm_*).
// Define ARBITER_ROUND_ROBIN_EN to alternate grants on simultaneous requests (default: dm wins).
module memory_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  dm_ready,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic [ADDR_WIDTH-1:0] memory_address,
  output logic [DATA_WIDTH-1:0] memory_wdata,
  output logic                  memory_we,
  input  logic [DATA_WIDTH-1:0] memory_data,
  output logic                  busy
);

  localparam int unsigned CntWidth = $clog2(WAIT_CYCLES + 1);
  localparam logic [CntWidth-1:0] CntLoad = CntWidth'(WAIT_CYCLES - 1);

  if (WAIT_CYCLES == 0) begin : gen_bad_wait
    $error("memory_arbiter: WAIT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e              state;
  logic [CntWidth-1:0] cnt;
  logic                sel_dm;
  logic                we_q;
  logic                dm_wins;

`ifdef ARBITER_ROUND_ROBIN_EN
  logic last_dm;
  assign dm_wins = dm_req && (!if_req || !last_dm);
`else
  assign dm_wins = dm_req;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= StIdle;
      cnt            <= '0;
      sel_dm         <= 1'b0;
      we_q           <= 1'b0;
      memory_address <= '0;
      memory_wdata   <= '0;
      memory_we      <= 1'b0;
      if_ready       <= 1'b0;
      dm_ready       <= 1'b0;
      if_rdata       <= '0;
      dm_rdata       <= '0;
      busy           <= 1'b0;
`ifdef ARBITER_ROUND_ROBIN_EN
      last_dm        <= 1'b0;
`endif
    end else begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      unique case (state)
        StIdle: begin
          if (if_req || dm_req) begin
            sel_dm         <= dm_wins;
            memory_address <= dm_wins ? dm_addr : if_addr;
            if (dm_wins) memory_wdata <= dm_wdata;
            we_q           <= dm_wins && dm_we;
            // With a single wait cycle the first ACCESS cycle is already the last one.
            memory_we      <= dm_wins && dm_we && (WAIT_CYCLES == 1);
            cnt            <= CntLoad;
            busy           <= 1'b1;
            state          <= StAccess;
`ifdef ARBITER_ROUND_ROBIN_EN
            last_dm        <= dm_wins;
`endif
          end
        end
        StAccess: begin
          if (cnt == '0) begin
            memory_we <= 1'b0;
            if (!we_q) begin
              if (sel_dm) dm_rdata <= memory_data;
              else        if_rdata <= memory_data;
            end
            if (sel_dm) dm_ready <= 1'b1;
            else        if_ready <= 1'b1;
            state <= StDone;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == CntWidth'(1)) memory_we <= we_q;
          end
        end
        StDone: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
